// File: rtl/rx_lbuf_ring.sv
`default_nettype none
// ============================================================================
// Module   : rx_lbuf_ring
// Purpose  : Snoops host MWr TLPs to program a ring of large-buffer slots and
//            offers armed slots to the consumer strictly in ring order.
// Revision : 1.0
// ============================================================================
module rx_lbuf_ring #(
    parameter int         BARHIT     = 2,
    parameter int         NUM_LBUF   = 4,
    parameter logic [5:0] BARMP_BASE = 6'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] trn_rd,
    input  logic [7:0]  trn_rrem_n,
    input  logic        trn_rsof_n,
    input  logic        trn_reof_n,
    input  logic        trn_rsrc_rdy_n,
    input  logic [6:0]  trn_rbar_hit_n,
    output logic [63:0] lbuf_addr,
    output logic        lbuf_en,
    output logic        lbuf64b,
    input  logic        lbuf_dn,
    output logic [3:0]  lbuf_armed_cnt,
    output logic [15:0] lbuf_ovr
);

    localparam int         c_LG   = $clog2(NUM_LBUF);
    localparam logic [6:0] c_SPAN = 7'(4 * NUM_LBUF);

    localparam logic [1:0] c_P_IDLE = 2'd0;
    localparam logic [1:0] c_P_DATA = 2'd1;
    localparam logic [1:0] c_P_SKIP = 2'd2;

    localparam logic [1:0] c_S_FREE   = 2'd0;
    localparam logic [1:0] c_S_ARMED  = 2'd1;
    localparam logic [1:0] c_S_ACTIVE = 2'd2;

    logic [1:0]      r_pst;
    logic [1:0]      r_st   [NUM_LBUF];
    logic [63:0]     r_addr [NUM_LBUF];
    logic [c_LG-1:0] r_hd;
    logic            r_en;
    logic [63:0]     r_lbuf_addr;
    logic            r_64b;
    logic [3:0]      r_cnt;
    logic [15:0]     r_ovr;

    logic            w_vld;
    logic            w_hdr_ok;
    logic            w_commit;
    logic [6:0]      w_rel;
    logic            w_hit;
    logic [c_LG-1:0] w_slot;
    logic [1:0]      w_reg;
    logic [31:0]     w_payload;
    logic            w_acc;
    logic            w_rej;
    logic            w_offer;
    logic            w_done;
    logic [1:0]      w_st_nxt [NUM_LBUF];
    logic [3:0]      w_cnt;
    logic            w_unused;

    assign w_vld    = !trn_rsrc_rdy_n;
    assign w_hdr_ok = !trn_rbar_hit_n[BARHIT] && (trn_rd[62:56] == 7'b1000000)
                      && (trn_rd[41:32] == 10'd1);
    assign w_commit = w_vld && (r_pst == c_P_DATA) && !trn_reof_n;

    // Offsets below the base wrap to large values, so one compare covers both ends.
    assign w_rel     = {1'b0, trn_rd[39:34]} - {1'b0, BARMP_BASE};
    assign w_reg     = w_rel[1:0];
    assign w_slot    = w_rel[2 +: c_LG];
    assign w_hit     = w_commit && (w_rel < c_SPAN) && (w_reg != 2'd3);
    assign w_payload = {trn_rd[7:0], trn_rd[15:8], trn_rd[23:16], trn_rd[31:24]};

    assign w_acc    = w_hit && (r_st[w_slot] == c_S_FREE);
    assign w_rej    = w_hit && (r_st[w_slot] != c_S_FREE);
    assign w_offer  = !r_en && (r_st[r_hd] == c_S_ARMED);
    assign w_done   = r_en && lbuf_dn;
    assign w_unused = ^{trn_rrem_n, trn_rd, trn_rbar_hit_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pst <= c_P_IDLE;
        end else if (w_vld) begin
            case (r_pst)
                c_P_IDLE: begin
                    // Beats without SOF are leftovers of a TLP cut by reset.
                    if (!trn_rsof_n && trn_reof_n)
                        r_pst <= w_hdr_ok ? c_P_DATA : c_P_SKIP;
                end
                c_P_DATA: r_pst <= trn_reof_n ? c_P_SKIP : c_P_IDLE;
                c_P_SKIP: if (!trn_reof_n) r_pst <= c_P_IDLE;
                default:  r_pst <= c_P_IDLE;
            endcase
        end
    end

    // A write to the slot being freed saw ACTIVE and was rejected, so the
    // offer/done updates never collide with an accepted write.
    always_comb begin
        w_st_nxt = r_st;
        if (w_acc && (w_reg == 2'd2) && w_payload[0])
            w_st_nxt[w_slot] = c_S_ARMED;
        if (w_offer)
            w_st_nxt[r_hd] = c_S_ACTIVE;
        if (w_done)
            w_st_nxt[r_hd] = c_S_FREE;
    end

    always_comb begin
        w_cnt = 4'd0;
        for (int i = 0; i < NUM_LBUF; i++) begin
            if (w_st_nxt[i] == c_S_ARMED)
                w_cnt = w_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LBUF; i++) begin
                r_st[i]   <= c_S_FREE;
                r_addr[i] <= 64'd0;
            end
            r_hd        <= '0;
            r_en        <= 1'b0;
            r_lbuf_addr <= 64'd0;
            r_64b       <= 1'b0;
            r_cnt       <= 4'd0;
            r_ovr       <= 16'd0;
        end else begin
            for (int i = 0; i < NUM_LBUF; i++)
                r_st[i] <= w_st_nxt[i];
            if (w_acc && (w_reg == 2'd0))
                r_addr[w_slot][31:0] <= w_payload;
            if (w_acc && (w_reg == 2'd1))
                r_addr[w_slot][63:32] <= w_payload;
            if (w_rej && (r_ovr != 16'hFFFF))
                r_ovr <= r_ovr + 16'd1;
            if (w_offer) begin
                r_en        <= 1'b1;
                r_lbuf_addr <= r_addr[r_hd];
                r_64b       <= |r_addr[r_hd][63:32];
            end
            if (w_done) begin
                r_en <= 1'b0;
                r_hd <= r_hd + 1'b1;
            end
            r_cnt <= w_cnt;
        end
    end

    assign lbuf_addr      = r_lbuf_addr;
    assign lbuf_en        = r_en;
    assign lbuf64b        = r_64b;
    assign lbuf_armed_cnt = r_cnt;
    assign lbuf_ovr       = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_rx_lbuf_ring.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_lbuf_ring
// Purpose  : Directed self-checking bench for rx_lbuf_ring (8-slot ring).
// Revision : 1.0
// ============================================================================
module tb_rx_lbuf_ring;

    localparam logic [6:0] c_HIT_OK  = 7'b1111011;
    localparam logic [6:0] c_HIT_BAD = 7'b1111101;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] trn_rd;
    logic [7:0]  trn_rrem_n;
    logic        trn_rsof_n;
    logic        trn_reof_n;
    logic        trn_rsrc_rdy_n;
    logic [6:0]  trn_rbar_hit_n;
    logic [63:0] lbuf_addr;
    logic        lbuf_en;
    logic        lbuf64b;
    logic        lbuf_dn;
    logic [3:0]  lbuf_armed_cnt;
    logic [15:0] lbuf_ovr;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_addr [8];

    rx_lbuf_ring #(.BARHIT(2), .NUM_LBUF(8), .BARMP_BASE(6'h00)) dut (
        .clk(clk), .rst(rst), .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n),
        .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
        .trn_rsrc_rdy_n(trn_rsrc_rdy_n), .trn_rbar_hit_n(trn_rbar_hit_n),
        .lbuf_addr(lbuf_addr), .lbuf_en(lbuf_en), .lbuf64b(lbuf64b),
        .lbuf_dn(lbuf_dn), .lbuf_armed_cnt(lbuf_armed_cnt), .lbuf_ovr(lbuf_ovr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [63:0] hdr(input logic [6:0] ft, input logic [9:0] len);
        return {1'b0, ft, 14'h0, len, 32'h0000_000F};
    endfunction

    function automatic logic [63:0] dbeat(input logic [5:0] off, input logic [31:0] val);
        return {24'h0, off, 2'b00, bswap(val)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        trn_rsrc_rdy_n = 1'b1;
        trn_rsof_n     = 1'b1;
        trn_reof_n     = 1'b1;
    endtask

    task automatic beat(input logic [63:0] d, input bit sof, input bit eof, input logic [6:0] hit);
        trn_rd         = d;
        trn_rsof_n     = !sof;
        trn_reof_n     = !eof;
        trn_rsrc_rdy_n = 1'b0;
        trn_rbar_hit_n = hit;
        tick();
        idle();
    endtask

    // Idle gap cycles carry junk SOF/EOF that must be ignored while not valid.
    task automatic tlp(input logic [63:0] h, input logic [6:0] hit, input logic [63:0] d2,
                       input bit eof2, input bit gap);
        beat(h, 1'b1, 1'b0, hit);
        if (gap) begin
            trn_rsof_n = 1'b0;
            trn_reof_n = 1'b0;
            tick();
            idle();
        end
        beat(d2, 1'b0, eof2, hit);
        if (!eof2) beat(d2, 1'b0, 1'b1, hit);
    endtask

    task automatic wr(input logic [5:0] off, input logic [31:0] val);
        tlp(hdr(7'h40, 10'd1), c_HIT_OK, dbeat(off, val), 1'b1, 1'b0);
    endtask

    task automatic done();
        lbuf_dn = 1'b1;
        tick();
        lbuf_dn = 1'b0;
    endtask

    task automatic wait_en(input string tag);
        int n = 0;
        while (lbuf_en !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk(tag, 64'(lbuf_en), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"},   64'(lbuf_en),        64'd0);
        chk({tag, "_addr"}, lbuf_addr,           64'd0);
        chk({tag, "_64b"},  64'(lbuf64b),        64'd0);
        chk({tag, "_cnt"},  64'(lbuf_armed_cnt), 64'd0);
        chk({tag, "_ovr"},  64'(lbuf_ovr),       64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; lbuf_dn = 1'b0; trn_rd = 64'd0; trn_rrem_n = 8'd0;
        trn_rbar_hit_n = 7'h7F; idle();
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // Slot 1 armed first must wait behind the FREE head slot 0.
        wr(6'd4, 32'h2000_0000); wr(6'd5, 32'h1); wr(6'd6, 32'h1);
        tick();
        chk("nonhead_en", 64'(lbuf_en), 64'd0);
        chk("nonhead_cnt", 64'(lbuf_armed_cnt), 64'd1);
        wr(6'd0, 32'h1000_0000); wr(6'd1, 32'h0); wr(6'd2, 32'h1);
        chk("lat_t1_en", 64'(lbuf_en), 64'd0);
        chk("lat_t1_cnt", 64'(lbuf_armed_cnt), 64'd2);
        tick();
        chk("lat_t2_en", 64'(lbuf_en), 64'd1);
        chk("s0_addr", lbuf_addr, 64'h0000_0000_1000_0000);
        chk("s0_64b", 64'(lbuf64b), 64'd0);
        chk("s0_cnt", 64'(lbuf_armed_cnt), 64'd1);

        wr(6'd0, 32'hDEAD_BEEF);
        chk("ovr_active", 64'(lbuf_ovr), 64'd1);
        chk("addr_stable", lbuf_addr, 64'h1000_0000);
        beat(hdr(7'h40, 10'd1), 1'b1, 1'b0, c_HIT_OK);
        lbuf_dn = 1'b1;
        beat(dbeat(6'd0, 32'hBEEF_0000), 1'b0, 1'b1, c_HIT_OK);
        lbuf_dn = 1'b0;
        chk("ovr_coincident", 64'(lbuf_ovr), 64'd2);
        chk("gap_after_dn", 64'(lbuf_en), 64'd0);
        tick();
        chk("s1_en", 64'(lbuf_en), 64'd1);
        chk("s1_addr", lbuf_addr, 64'h0000_0001_2000_0000);
        chk("s1_64b", 64'(lbuf64b), 64'd1);
        chk("s1_cnt", 64'(lbuf_armed_cnt), 64'd0);
        done();
        chk("s1_done_en", 64'(lbuf_en), 64'd0);

        // Head is slot 2; none of these may touch any slot.
        tlp(hdr(7'h40, 10'd2), c_HIT_OK,  dbeat(6'd10, 32'h1), 1'b1, 1'b0);
        tlp(hdr(7'h40, 10'd1), c_HIT_BAD, dbeat(6'd10, 32'h1), 1'b1, 1'b0);
        tlp(hdr(7'h60, 10'd1), c_HIT_OK,  dbeat(6'd10, 32'h1), 1'b0, 1'b0);
        tlp(hdr(7'h40, 10'd1), c_HIT_OK,  dbeat(6'd10, 32'h1), 1'b0, 1'b0);
        wr(6'd32, 32'hFFFF_FFF0);
        repeat (2) tick();
        chk("ign_cnt", 64'(lbuf_armed_cnt), 64'd0);
        chk("ign_en", 64'(lbuf_en), 64'd0);
        chk("ign_ovr", 64'(lbuf_ovr), 64'd2);

        tlp(hdr(7'h40, 10'd1), c_HIT_OK, dbeat(6'd8, 32'h3000_0040), 1'b1, 1'b1);
        tlp(hdr(7'h40, 10'd1), c_HIT_OK, dbeat(6'd10, 32'h1), 1'b1, 1'b1);
        wait_en("gap_offer");
        chk("gap_addr", lbuf_addr, 64'h3000_0040);
        wr(6'd11, 32'h1);
        chk("reserved_ovr", 64'(lbuf_ovr), 64'd2);
        done();

        // Ring wrap: head at 3, arm 3..7 then 0..2, offers must follow ring order.
        exp_addr[0] = 64'h0000_0000_1000_0000;
        exp_addr[1] = 64'h0000_0001_2000_0000;
        exp_addr[2] = 64'h0000_0000_3000_0040;
        for (int s = 3; s < 8; s++) begin
            exp_addr[s] = {32'h0, 32'(s) << 28};
            wr(6'(4 * s), 32'(s) << 28);
        end
        for (int k = 0; k < 8; k++)
            wr(6'(4 * ((3 + k) % 8) + 2), 32'h1);
        tick();
        chk("wrap_cnt_full", 64'(lbuf_armed_cnt), 64'd7);
        for (int k = 0; k < 8; k++) begin
            wait_en($sformatf("wrap_en_%0d", k));
            chk($sformatf("wrap_addr_%0d", k), lbuf_addr, exp_addr[(3 + k) % 8]);
            chk($sformatf("wrap_cnt_%0d", k), 64'(lbuf_armed_cnt), 64'(7 - k));
            done();
            chk($sformatf("wrap_gap_%0d", k), 64'(lbuf_en), 64'd0);
        end

        // lbuf_dn while idle must not advance the head (still slot 3).
        done();
        tick();
        wr(6'd14, 32'h1);
        wait_en("idle_dn_offer");
        chk("idle_dn_addr", lbuf_addr, 64'h3000_0000);

        wr(6'd18, 32'h1); wr(6'd22, 32'h1); wr(6'd26, 32'h1);
        chk("pre_rst_cnt", 64'(lbuf_armed_cnt), 64'd3);
        beat(hdr(7'h40, 10'd1), 1'b1, 1'b0, c_HIT_OK);
        rst = 1'b1;
        tick();
        chk_zero("midrst");
        rst = 1'b0;
        beat(dbeat(6'd2, 32'h1), 1'b0, 1'b1, c_HIT_OK);
        tick();
        chk("tail_cnt", 64'(lbuf_armed_cnt), 64'd0);
        chk("tail_en", 64'(lbuf_en), 64'd0);
        wr(6'd4, 32'h0000_5000); wr(6'd6, 32'h1);
        tick();
        chk("post_rst_s1_en", 64'(lbuf_en), 64'd0);
        chk("post_rst_cnt", 64'(lbuf_armed_cnt), 64'd1);
        wr(6'd0, 32'h7000_0000); wr(6'd2, 32'h1);
        wait_en("post_rst_offer");
        chk("post_rst_addr", lbuf_addr, 64'h7000_0000);
        chk("post_rst_64b", 64'(lbuf64b), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
